// File: rtl/sd_block_arbiter.sv
//
// sd_block_arbiter
// ----------------
// Shares the single HPS virtual-SD block channel (sd_lba / sd_rd / sd_wr /
// sd_ack / sd_buff_wr) between NREQ drive requesters (FDD0, FDD1, HDD, spare).
// One sector transaction runs at a time. The owner is chosen round-robin
// among pending requesters. Its LBA and operation are latched at grant time,
// and completion is reported back with a one-cycle pulse to that requester
// only.
//
// Build option:
//   SD_ARB_TIMEOUT_EN  when defined, a TMO_W-bit watchdog aborts a transaction
//                      that stalls in WAIT_ACK/XFER and pulses req_err instead
//                      of req_done. When undefined, req_err is tied to 0 and
//                      the arbiter waits for the ack forever.
//
// Parameters:
//   NREQ   number of requesters (bit i of every NREQ-wide port is requester i)
//   LBA_W  sector address width
//   TMO_W  watchdog counter width (timeout build only)
//
// Ports:
//   clk_sys      in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   req_rd       in   [NREQ]        level read request, held until req_done
//   req_wr       in   [NREQ]        level write request, held until req_done
//   req_lba      in   [NREQ*LBA_W]  sector address, requester i at [i*LBA_W +: LBA_W]
//   req_done     out  [NREQ]        one-cycle completion pulse to the owner
//   req_err      out  [NREQ]        one-cycle abort pulse (timeout build only)
//   req_buff_wr  out  [NREQ]        sd_buff_wr steered to the owner only
//   grant        out  [NREQ]        one-hot current owner, 0 when idle
//   busy         out                high in every state except IDLE
//   sd_lba       out  [LBA_W]       latched LBA of the granted request
//   sd_rd        out  [NREQ]        read strobe to hps_io, owner bit only
//   sd_wr        out  [NREQ]        write strobe to hps_io, owner bit only
//   sd_ack       in   [NREQ]        ack from hps_io, only the owner bit is used
//   sd_buff_wr   in                 buffer byte write strobe from hps_io

module sd_block_arbiter #(
  parameter int NREQ  = 4,
  parameter int LBA_W = 32,
  parameter int TMO_W = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_err,
  output logic [NREQ-1:0]       req_buff_wr,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [LBA_W-1:0]      sd_lba,
  output logic [NREQ-1:0]       sd_rd,
  output logic [NREQ-1:0]       sd_wr,
  input  logic [NREQ-1:0]       sd_ack,
  input  logic                  sd_buff_wr
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_XFER,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_idx;
  logic             op_wr;
  logic [NREQ-1:0]  pending;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic [NREQ-1:0]  win_onehot;
  logic             owner_ack;
  logic             strobe_on;
  logic             tmo_hit;
  logic             aborted;

  assign pending    = req_rd | req_wr;
  assign win_onehot = NREQ'(1) << win_idx;
  assign owner_ack  = sd_ack[owner_idx];

  // Round-robin search: the first pending requester at or after rr_ptr,
  // wrapping from NREQ-1 back to 0. cand carries one extra bit so that the
  // sum can exceed NREQ-1 before it is folded back into range.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!found && pending[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  // Watchdog: cleared while issuing, counts through WAIT_ACK and XFER. An ack
  // arriving in the same cycle as the all-ones count still wins, so a
  // transaction that completes on the last cycle is not reported as aborted.
  logic [TMO_W-1:0] tmo_cnt;
  logic             abort_now;

  assign tmo_hit   = &tmo_cnt;
  assign abort_now = tmo_hit &&
                     (((state == S_WAIT_ACK) && !owner_ack) ||
                      ((state == S_XFER) && owner_ack));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      aborted <= 1'b0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
      aborted <= 1'b0;
    end else if ((state == S_WAIT_ACK) || (state == S_XFER)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      aborted <= abort_now;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign aborted = 1'b0;
`endif

  // Next-state logic. A request is committed once ISSUE is entered, so none
  // of the later transitions look at req_rd/req_wr again.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (owner_ack) begin
          state_next = S_XFER;
        end else if (tmo_hit) begin
          state_next = S_DONE;
        end
      end
      S_XFER: begin
        if (!owner_ack || tmo_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register plus the per-transaction context. Owner, LBA and op are
  // captured only on the IDLE->ISSUE step, so later changes on req_lba or the
  // request levels cannot disturb a running transaction. The round-robin
  // pointer moves past the owner only when the transaction retires.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner_idx <= '0;
      op_wr     <= 1'b0;
      grant     <= '0;
      sd_lba    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner_idx <= win_idx;
            grant     <= win_onehot;
            sd_lba    <= req_lba[win_idx*LBA_W +: LBA_W];
            op_wr     <= req_wr[win_idx];
          end
        end
        S_DONE: begin
          rr_ptr <= (owner_idx == IDX_W'(NREQ-1)) ? '0 : owner_idx + 1'b1;
          grant  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes run from ISSUE until the cycle after the owner's ack is sampled.
  // A write wins over a read for the same requester so that dirty data is
  // flushed before the sector is read back.
  assign strobe_on   = (state == S_ISSUE) || (state == S_WAIT_ACK);
  assign sd_rd       = (strobe_on && !op_wr) ? grant : '0;
  assign sd_wr       = (strobe_on && op_wr) ? grant : '0;
  assign busy        = (state != S_IDLE);
  assign req_buff_wr = sd_buff_wr ? grant : '0;
  assign req_done    = ((state == S_DONE) && !aborted) ? grant : '0;

`ifdef SD_ARB_TIMEOUT_EN
  assign req_err = ((state == S_DONE) && aborted) ? grant : '0;
`else
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_sd_block_arbiter.sv
//
// tb_sd_block_arbiter
// Self-checking bench for sd_block_arbiter (default build, NREQ=4, LBA_W=32).
// A cycle table covers a single read, stray acks, rd+wr priority and
// commitment. Hand sequences cover reset in the middle of a transfer and the
// round-robin order. A randomized phase then compares the DUT with a
// transaction-level reference model.

module tb_sd_block_arbiter;

  localparam int NREQ  = 4;
  localparam int LBA_W = 32;

  logic                  clk_sys = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_rd;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ*LBA_W-1:0] req_lba;
  logic [NREQ-1:0]       req_done;
  logic [NREQ-1:0]       req_err;
  logic [NREQ-1:0]       req_buff_wr;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [LBA_W-1:0]      sd_lba;
  logic [NREQ-1:0]       sd_rd;
  logic [NREQ-1:0]       sd_wr;
  logic [NREQ-1:0]       sd_ack;
  logic                  sd_buff_wr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  sd_block_arbiter #(.NREQ(NREQ), .LBA_W(LBA_W), .TMO_W(24)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba     (req_lba),
    .req_done    (req_done),
    .req_err     (req_err),
    .req_buff_wr (req_buff_wr),
    .grant       (grant),
    .busy        (busy),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] lba;
    logic [3:0]  ack;
    logic        buff;
    logic [3:0]  e_grant;
    logic [3:0]  e_rd;
    logic [3:0]  e_wr;
    logic [3:0]  e_done;
    logic [3:0]  e_bwr;
    logic        e_busy;
    logic [31:0] e_lba;
    logic        chk_lba;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk_vec(
    input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] lba,
    input logic [3:0] ack, input logic buff,
    input logic [3:0] e_grant, input logic [3:0] e_rd, input logic [3:0] e_wr,
    input logic [3:0] e_done, input logic [3:0] e_bwr, input logic e_busy,
    input logic [31:0] e_lba, input logic chk_lba);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lba = lba; v.ack = ack; v.buff = buff;
    v.e_grant = e_grant; v.e_rd = e_rd; v.e_wr = e_wr; v.e_done = e_done;
    v.e_bwr = e_bwr; v.e_busy = e_busy; v.e_lba = e_lba; v.chk_lba = chk_lba;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 4 units later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_rd     = '0;
    req_wr     = '0;
    req_lba    = '0;
    sd_ack     = '0;
    sd_buff_wr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_rd     = v.rd;
    req_wr     = v.wr;
    req_lba    = {4{v.lba}};
    sd_ack     = v.ack;
    sd_buff_wr = v.buff;
  endtask

  // One full transaction with all requests held: wait for the grant, ack it
  // on the first WAIT_ACK cycle, keep the ack for one XFER cycle, then drop it.
  task automatic run_txn(input logic [3:0] exp_g, input string tag, input bit chk_gap);
    int waited;
    waited = 0;
    do begin
      tick();
      #4;
      waited++;
    end while (grant == '0 && waited < 20);
    check_output({tag, " grant"}, grant, exp_g);
    check_output({tag, " sd_rd"}, sd_rd, exp_g);
    if (chk_gap) check_output({tag, " regrant gap"}, waited, 1);
    tick(); sd_ack = exp_g; #4;
    tick(); #4;
    check_output({tag, " strobe off in xfer"}, sd_rd, 4'b0000);
    tick(); sd_ack = '0; #4;
    tick(); #4;
    check_output({tag, " done"}, req_done, exp_g);
    tick(); #4;
    check_output({tag, " idle busy"}, busy, 1'b0);
    check_output({tag, " done cleared"}, req_done, 4'b0000);
  endtask

  // Spec rule: the first pending index at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] p, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (p[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    logic [3:0] rr_order [6];
    // Reference model state for the randomized phase.
    int          m_owner;
    int          m_rr;
    bit          m_wr;
    bit          m_strobe;
    bit          m_first;
    bit          m_xfer;
    bit          m_done;
    bit          m_idle_prev;
    logic [31:0] m_lba;
    logic [3:0]  exp_grant;
    logic [3:0]  prev_rd;
    logic [3:0]  prev_wr;
    logic [127:0] prev_lba;
    int          wait_cnt [4];
    int          served;
    int          winner;
    // Environment state (requesters and hps_io responder).
    logic [3:0]  obs_done;
    logic [3:0]  obs_strobe;
    logic [3:0]  own_ack;
    int          resp_delay;
    int          resp_hold;
    logic [3:0]  stray;
    int          r;

    // Reset state, asserted and held.
    reset      = 1'b1;
    req_rd     = '0;
    req_wr     = '0;
    req_lba    = '0;
    sd_ack     = '0;
    sd_buff_wr = 1'b0;
    #3;
    check_output("reset grant", grant, 4'b0000);
    check_output("reset busy", busy, 1'b0);
    check_output("reset sd_lba", sd_lba, 32'h0);
    check_output("reset sd_rd", sd_rd, 4'b0000);
    check_output("reset sd_wr", sd_wr, 4'b0000);
    check_output("reset req_done", req_done, 4'b0000);
    check_output("reset req_err", req_err, 4'b0000);
    do_reset();

    // rd      wr      lba    ack     bf | grant   rd      wr      done    bwr     bsy lba    chk
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h10, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 32'h00, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h10, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h10, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h10, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h99, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h99, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0001, 4'b0000, 32'h99, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h99, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 32'h10, 1));
    tbl.push_back(mk_vec(4'b0100, 4'b0100, 32'h2A, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 32'h00, 0));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0001, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0100, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0101, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b0000, 4'b0000, 32'h2A, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1, 32'h2A, 1));
    tbl.push_back(mk_vec(4'b1011, 4'b0000, 32'h33, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 32'h00, 0));
    tbl.push_back(mk_vec(4'b1011, 4'b0000, 32'h33, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 32'h33, 1));

    foreach (tbl[i]) begin
      tick();
      apply_stimulus(tbl[i]);
      #4;
      check_output($sformatf("tbl[%0d] grant", i), grant, tbl[i].e_grant);
      check_output($sformatf("tbl[%0d] sd_rd", i), sd_rd, tbl[i].e_rd);
      check_output($sformatf("tbl[%0d] sd_wr", i), sd_wr, tbl[i].e_wr);
      check_output($sformatf("tbl[%0d] req_done", i), req_done, tbl[i].e_done);
      check_output($sformatf("tbl[%0d] req_buff_wr", i), req_buff_wr, tbl[i].e_bwr);
      check_output($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
      if (tbl[i].chk_lba) check_output($sformatf("tbl[%0d] sd_lba", i), sd_lba, tbl[i].e_lba);
    end

    // Owner 3 (pointer at 3) goes into XFER, then reset hits mid-cycle.
    tick(); sd_ack = 4'b1000; #4;
    check_output("pre-reset wait_ack sd_rd", sd_rd, 4'b1000);
    tick(); #2;
    check_output("pre-reset xfer grant", grant, 4'b1000);
    reset = 1'b1;
    #1;
    check_output("async reset grant", grant, 4'b0000);
    check_output("async reset sd_rd", sd_rd, 4'b0000);
    check_output("async reset busy", busy, 1'b0);
    check_output("async reset sd_lba", sd_lba, 32'h0);
    @(posedge clk_sys);
    #1;
    reset  = 1'b0;
    sd_ack = '0;
    req_rd = 4'b1001;
    req_wr = '0;
    tick(); #4;
    check_output("post-reset scan from 0 grant", grant, 4'b0001);
    check_output("post-reset scan from 0 sd_rd", sd_rd, 4'b0001);

    // Round robin with 0, 1 and 3 held: 0,1,3,0,1,3.
    do_reset();
    req_rd = 4'b1011;
    rr_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    for (int t = 0; t < 6; t++) begin
      run_txn(rr_order[t], $sformatf("rr txn %0d", t), t != 0);
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_owner     = -1;
    m_rr        = 0;
    m_wr        = 1'b0;
    m_strobe    = 1'b0;
    m_first     = 1'b0;
    m_xfer      = 1'b0;
    m_done      = 1'b0;
    m_idle_prev = 1'b1;
    m_lba       = '0;
    prev_rd     = '0;
    prev_wr     = '0;
    prev_lba    = '0;
    served      = 0;
    obs_done    = '0;
    obs_strobe  = '0;
    own_ack     = '0;
    resp_delay  = 0;
    resp_hold   = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      // Requesters: drop on completion, otherwise occasionally raise a new one.
      for (int i = 0; i < NREQ; i++) begin
        if (obs_done[i]) begin
          req_rd[i] = 1'b0;
          req_wr[i] = 1'b0;
        end else if (!req_rd[i] && !req_wr[i] && $urandom_range(0, 4) == 0) begin
          r = $urandom_range(0, 2);
          req_rd[i] = (r != 1);
          req_wr[i] = (r != 0);
        end
        if ($urandom_range(0, 3) == 0) req_lba[i*LBA_W +: LBA_W] = $urandom;
      end
      // hps_io responder: ack after a random delay, hold it 1-4 cycles.
      if (own_ack != '0) begin
        if (resp_hold == 0) own_ack = '0;
        else resp_hold--;
      end else if (obs_strobe != '0) begin
        if (resp_delay == 0) begin
          own_ack    = obs_strobe;
          resp_hold  = $urandom_range(0, 3);
          resp_delay = $urandom_range(0, 3);
        end else begin
          resp_delay--;
        end
      end
      stray      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      sd_ack     = own_ack | stray;
      sd_buff_wr = 1'($urandom_range(0, 1));
      #4;

      if (m_owner < 0 && m_idle_prev && (prev_rd | prev_wr) != '0) begin
        winner = pick(prev_rd | prev_wr, m_rr);
        for (int j = 0; j < NREQ; j++) begin
          if (j != winner && (prev_rd[j] || prev_wr[j])) wait_cnt[j]++;
        end
        check_output("rnd starvation bound", wait_cnt[winner] < NREQ, 1);
        wait_cnt[winner] = 0;
        m_owner  = winner;
        m_wr     = prev_wr[winner];
        m_lba    = prev_lba[winner*LBA_W +: LBA_W];
        m_strobe = 1'b1;
        m_first  = 1'b1;
        m_xfer   = 1'b0;
        m_done   = 1'b0;
      end

      exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      check_output("rnd grant", grant, exp_grant);
      check_output("rnd busy", busy, m_owner >= 0);
      check_output("rnd sd_rd", sd_rd, (m_strobe && !m_wr) ? exp_grant : 4'b0000);
      check_output("rnd sd_wr", sd_wr, (m_strobe && m_wr) ? exp_grant : 4'b0000);
      check_output("rnd req_done", req_done, m_done ? exp_grant : 4'b0000);
      check_output("rnd req_buff_wr", req_buff_wr, sd_buff_wr ? exp_grant : 4'b0000);
      check_output("rnd req_err", req_err, 4'b0000);
      if (m_owner >= 0) check_output("rnd sd_lba", sd_lba, m_lba);

      // Advance the model by one cycle.
      m_idle_prev = (m_owner < 0);
      if (m_owner >= 0) begin
        if (m_done) begin
          m_rr    = (m_owner + 1) % NREQ;
          m_owner = -1;
          m_done  = 1'b0;
          served++;
        end else if (m_strobe) begin
          if (!m_first && sd_ack[m_owner]) begin
            m_strobe = 1'b0;
            m_xfer   = 1'b1;
          end
          m_first = 1'b0;
        end else if (m_xfer) begin
          if (!sd_ack[m_owner]) begin
            m_xfer = 1'b0;
            m_done = 1'b1;
          end
        end
      end

      obs_done   = req_done;
      obs_strobe = sd_rd | sd_wr;
      prev_rd    = req_rd;
      prev_wr    = req_wr;
      prev_lba   = req_lba;
    end
    check_output("rnd transactions completed", served > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
